// File: rtl/reg_seq.sv
// reg_seq: multi-cycle sequencer that runs MOV/ADD/SUB/SWAP on an external
// single-port register file. Address 3 is the read-only user input.
module reg_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] dst,
  input  logic [1:0] src,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       carry,
  output logic [1:0] rf_a,
  output logic       rf_ce,
  output logic [7:0] rf_in,
  input  logic [7:0] rf_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_SRC = 3'd1,
    S_RD_DST = 3'd2,
    S_WR_DST = 3'd3,
    S_WR_SRC = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] OP_MOV  = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_SWAP = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d, dst_q, dst_d, src_q, src_d;
  logic [7:0] tmp_s_q, tmp_s_d, tmp_d_q, tmp_d_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d, err_q, err_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [1:0] rf_a_s;
  logic       rf_ce_s;
  logic [7:0] rf_in_s;
  logic [8:0] sum_s, diff_s;
  logic       illegal_s;

  // Bit 8 of the 9-bit difference is the borrow, i.e. tmp_d < tmp_s.
  assign sum_s     = {1'b0, tmp_d_q} + {1'b0, tmp_s_q};
  assign diff_s    = {1'b0, tmp_d_q} - {1'b0, tmp_s_q};
  assign illegal_s = (dst == 2'd3) || ((src == 2'd3) && (op == OP_SWAP));

  // Next-state, datapath and register-file port decode.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src_d    = src_q;
    tmp_s_d  = tmp_s_q;
    tmp_d_d  = tmp_d_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    rf_a_s   = 2'd0;
    rf_ce_s  = 1'b0;
    rf_in_s  = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          dst_d = dst;
          src_d = src;
          if (illegal_s) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RD_SRC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_SRC: begin
        rf_a_s  = src_q;
        tmp_s_d = rf_out;
        state_d = (op_q == OP_MOV) ? S_WR_DST : S_RD_DST;
      end
      S_RD_DST: begin
        rf_a_s  = dst_q;
        tmp_d_d = rf_out;
        state_d = S_WR_DST;
      end
      S_WR_DST: begin
        rf_a_s  = dst_q;
        rf_ce_s = 1'b1;
        case (op_q)
          OP_ADD: begin
            rf_in_s = sum_s[7:0];
            carry_d = sum_s[8];
          end
          OP_SUB: begin
            rf_in_s = diff_s[7:0];
            carry_d = diff_s[8];
          end
          default: begin
            rf_in_s = tmp_s_q;
            carry_d = 1'b0;
          end
        endcase
        result_d = rf_in_s;
        state_d  = (op_q == OP_SWAP) ? S_WR_SRC : S_DONE;
      end
      S_WR_SRC: begin
        rf_a_s  = src_q;
        rf_ce_s = 1'b1;
        rf_in_s = tmp_d_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      dst_q    <= 2'd0;
      src_q    <= 2'd0;
      tmp_s_q  <= 8'd0;
      tmp_d_q  <= 8'd0;
      result_q <= 8'd0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      tmp_s_q  <= tmp_s_d;
      tmp_d_q  <= tmp_d_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign rf_a   = rf_a_s;
  // A reset landing on a write cycle must not commit that write.
  assign rf_ce  = rf_ce_s & ~rst;
  assign rf_in  = rf_in_s;

endmodule

// File: tb/tb_reg_seq.sv
// Randomized self-checking bench for reg_seq: a behavioural register-file
// model predicts register contents, result/carry/err, latency and write count.
module tb_reg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0, dst = 2'd0, src = 2'd0;
  logic       busy, done, err, carry, rf_ce;
  logic [7:0] result, rf_in, rf_out;
  logic [1:0] rf_a;

  logic [7:0] user_in = 8'd0;
  logic [7:0] mem [0:3];
  logic       pre_we = 1'b0;
  logic [1:0] pre_a = 2'd0;
  logic [7:0] pre_d = 8'd0;
  int         wr_cnt = 0;

  logic [7:0] ref_rf [0:3];
  logic [7:0] exp_result = 8'd0;
  logic       exp_carry = 1'b0;
  logic       exp_err = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  reg_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst), .src(src),
    .busy(busy), .done(done), .err(err), .result(result), .carry(carry),
    .rf_a(rf_a), .rf_ce(rf_ce), .rf_in(rf_in), .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  assign rf_out = (rf_a == 2'd3) ? user_in : mem[rf_a];

  always @(posedge clk) begin
    if (rf_ce) begin
      mem[rf_a] <= rf_in;
      wr_cnt    <= wr_cnt + 1;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_rf[a] = d;
  endtask

  // Reference semantics of one accepted operation.
  task automatic model_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                          output int e_lat, output int e_w);
    int a, b, t;
    a = int'(ref_rf[s]);
    b = int'(ref_rf[d]);
    if (d == 2'd3 || (o == 2'd3 && s == 2'd3)) begin
      exp_err = 1'b1; e_lat = 1; e_w = 0;
    end else begin
      exp_err = 1'b0;
      case (o)
        2'd0: begin
          ref_rf[d] = 8'(a); exp_result = 8'(a); exp_carry = 1'b0; e_lat = 3; e_w = 1;
        end
        2'd1: begin
          t = b + a;
          ref_rf[d] = 8'(t % 256); exp_result = 8'(t % 256); exp_carry = (t > 255);
          e_lat = 4; e_w = 1;
        end
        2'd2: begin
          t = b - a + 256;
          ref_rf[d] = 8'(t % 256); exp_result = 8'(t % 256); exp_carry = (b < a);
          e_lat = 4; e_w = 1;
        end
        default: begin
          ref_rf[d] = 8'(a); ref_rf[s] = 8'(b); exp_result = 8'(a); exp_carry = 1'b0;
          e_lat = 5; e_w = 2;
        end
      endcase
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_r%0d", tag, i), mem[i], ref_rf[i]);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                        input bit pulse_ign);
    int lat, w0, e_lat, e_w;
    ref_rf[3] = user_in;
    model_op(o, d, s, e_lat, e_w);
    w0 = wr_cnt;
    op = o; dst = d; src = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      if (pulse_ign && lat == 1) begin
        start = 1'b1;
        op = 2'($urandom_range(3, 0)); dst = 2'($urandom_range(3, 0)); src = 2'($urandom_range(3, 0));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("latency", lat, e_lat);
    chk("busy_in_done", busy, 1'b0);
    chk("err", err, exp_err);
    chk("result", result, exp_result);
    chk("carry", carry, exp_carry);
    chk("writes", wr_cnt - w0, e_w);
    chk("rf_ce_done", rf_ce, 1'b0);
    chk("rf_a_done", rf_a, 2'd0);
    check_regs("op");
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int w0, cyc, first, second, idle_seen, e_lat, e_w;
    logic [7:0] keep;

    // reset wins over a simultaneous start
    start = 1'b1; op = 2'd1; dst = 2'd0; src = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_result", result, 8'd0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_rf_ce", rf_ce, 1'b0);
    chk("rst_rf_in", rf_in, 8'd0);
    start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 3; i++) preload(2'(i), 8'($urandom_range(255, 0)));

    // MOV r0 <- r1
    preload(2'd1, 8'h5A);
    run_op(2'd0, 2'd0, 2'd1, 1'b0);
    chk("mov_r0", mem[0], 8'h5A);
    // ADD r0 += r2 with carry, then SUB r2 -= r0
    preload(2'd0, 8'hF0); preload(2'd2, 8'h20);
    run_op(2'd1, 2'd0, 2'd2, 1'b0);
    chk("add_r0", mem[0], 8'h10);
    chk("add_carry", carry, 1'b1);
    run_op(2'd2, 2'd2, 2'd0, 1'b0);
    chk("sub_r2", mem[2], 8'h10);
    // SWAP r0 <-> r1
    preload(2'd0, 8'h11); preload(2'd1, 8'h22);
    run_op(2'd3, 2'd0, 2'd1, 1'b0);
    chk("swap_r0", mem[0], 8'h22);
    chk("swap_r1", mem[1], 8'h11);
    // illegal: dst=3, SWAP with src=3, then a legal op clears err
    run_op(2'd0, 2'd3, 2'd0, 1'b0);
    run_op(2'd3, 2'd0, 2'd3, 1'b0);
    user_in = 8'hC3;
    run_op(2'd1, 2'd1, 2'd3, 1'b0);
    // dst == src corner cases
    run_op(2'd2, 2'd1, 2'd1, 1'b0);
    run_op(2'd3, 2'd2, 2'd2, 1'b0);

    // reset asserted during the WR_DST cycle of an ADD
    preload(2'd0, 8'h37); preload(2'd1, 8'h44);
    keep = 8'h37;
    w0 = wr_cnt;
    op = 2'd1; dst = 2'd0; src = 2'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("wr_dst_ce", rf_ce, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_forces_ce", rf_ce, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_r0", mem[0], keep);
    chk("midrst_writes", wr_cnt - w0, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 8'd0);
    chk("midrst_carry", carry, 1'b0);
    chk("midrst_rf_a", rf_a, 2'd0);
    exp_result = 8'd0; exp_carry = 1'b0; exp_err = 1'b0;

    // start held high: two ADDs back to back with one IDLE cycle between
    ref_rf[3] = user_in;
    model_op(2'd1, 2'd0, 2'd1, e_lat, e_w);
    model_op(2'd1, 2'd0, 2'd1, e_lat, e_w);
    op = 2'd1; dst = 2'd0; src = 2'd1; start = 1'b1;
    cyc = 0; first = -1; second = -1; idle_seen = 0;
    while (second < 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end else if (first >= 0 && !busy) begin
        idle_seen++;
      end
    end
    start = 1'b0;
    chk("b2b_first", first, 4);
    chk("b2b_gap", second - first, 5);
    chk("b2b_idle", idle_seen, 1);
    chk("b2b_result", result, exp_result);
    chk("b2b_carry", carry, exp_carry);
    @(posedge clk); #1;
    chk("b2b_stop", busy | done, 1'b0);
    check_regs("b2b");

    // start pulsed while busy is ignored
    run_op(2'd3, 2'd1, 2'd2, 1'b1);
    run_op(2'd0, 2'd2, 2'd0, 1'b1);

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      user_in = 8'($urandom_range(255, 0));
      if ($urandom_range(3, 0) == 0) preload(2'($urandom_range(2, 0)), 8'($urandom_range(255, 0)));
      run_op(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
